nic_fifo: RTL

- Parametrised successor to the single-entry network interface controller; sits between the processor's memory-mapped NIC port and the ring router's local port.
- Replaces the one-word input and output buffers with FIFOs of configurable depth and data width.
- Keeps the polarity-gated send rule and adds occupancy counts to the status words, so software can batch transfers.

---
 rtl/nic_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/nic_fifo.sv
// nic_fifo: NIC between the processor's memory-mapped port and the ring
// router's local port. Output and input words are buffered in FIFOs. A send
// is gated by the virtual-channel bit (bit 0, MSB) against router polarity.

// Count-based circular buffer; head reads 0 while empty.
module nic_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [0:W-1]     din,
  input  logic             pop,
  output logic [0:W-1]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [0:W-1]     mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // full/empty sampled from the registered count, so a push into a full
  // buffer is dropped even when a pop frees a slot in the same cycle
  assign do_push = push & ~full;
  assign do_pop  = pop  & ~empty;
  assign head    = empty ? '0 : mem[rptr];

  // storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // pointers wrap naturally (power-of-2 depth); count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module nic_fifo #(
  parameter int DATA_W    = 64,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [0:DATA_W-1] d_in,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic [0:DATA_W-1] d_out,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di
);
  localparam int OCNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int ICNT_W = $clog2(IN_DEPTH) + 1;

  localparam logic [1:0] A_IN_BUF  = 2'b00;
  localparam logic [1:0] A_IN_STAT = 2'b01;
  localparam logic [1:0] A_OUT_BUF = 2'b10;
  localparam logic [1:0] A_OUT_STAT= 2'b11;

  logic [0:DATA_W-1] out_head, in_head;
  logic [OCNT_W-1:0] out_cnt;
  logic [ICNT_W-1:0] in_cnt;
  logic              out_full, out_empty, in_full, in_empty;
  logic              out_push, in_pop;
  logic [0:DATA_W-1] in_stat, out_stat;

  assign out_push = nicEn & nicWrEn  & (addr == A_OUT_BUF);
  assign in_pop   = nicEn & ~nicWrEn & (addr == A_IN_BUF);

  nic_fifo_buf #(.DEPTH(OUT_DEPTH), .W(DATA_W)) u_out (
    .clk(clk), .reset(reset),
    .push(out_push), .din(d_in),
    .pop(net_so), .head(out_head),
    .count(out_cnt), .full(out_full), .empty(out_empty)
  );

  nic_fifo_buf #(.DEPTH(IN_DEPTH), .W(DATA_W)) u_in (
    .clk(clk), .reset(reset),
    .push(net_si), .din(net_di),
    .pop(in_pop), .head(in_head),
    .count(in_cnt), .full(in_full), .empty(in_empty)
  );

  assign net_do = out_head;
  assign net_ri = ~in_full;
  // send only when the head's channel bit opposes the router's polarity
  assign net_so = ~out_empty & net_ro & (out_head[0] == ~net_polarity);

  // status words: flag in the numeric LSB, occupancy count just above it
  always_comb begin
    in_stat  = '0;
    out_stat = '0;
    in_stat [DATA_W-1-ICNT_W +: ICNT_W+1] = {in_cnt,  ~in_empty};
    out_stat[DATA_W-1-OCNT_W +: OCNT_W+1] = {out_cnt, out_full};
  end

  // registered read port; writes leave d_out untouched
  always_ff @(posedge clk) begin
    if (reset || !nicEn) begin
      d_out <= '0;
    end else if (!nicWrEn) begin
      case (addr)
        A_IN_BUF:   d_out <= in_head;
        A_IN_STAT:  d_out <= in_stat;
        A_OUT_BUF:  d_out <= '0;
        A_OUT_STAT: d_out <= out_stat;
        default:    d_out <= '0;
      endcase
    end
  end
endmodule
